// File: rtl/conv_controller_if.sv
// Signal bundle between the convolution controller, its pixel source,
// the datapath it sequences and the result consumer.
interface conv_controller_if #(
  parameter int DATA_WIDTH = 16,
  parameter int IMAGE_SIZE = 28
);
  localparam int CW = $clog2(IMAGE_SIZE);

  logic                  start;
  logic                  pix_valid;
  logic [DATA_WIDTH-1:0] pix_data;
  logic                  pix_ready;
  logic                  dp_write;
  logic [DATA_WIDTH-1:0] dp_pixel;
  logic [DATA_WIDTH-1:0] dp_result;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic [CW-1:0]         out_row;
  logic [CW-1:0]         out_col;
  logic                  busy;
  logic                  done;

  // The controller is the master: it sequences the datapath and the output stream.
  modport master (
    input  start, pix_valid, pix_data, dp_result,
    output pix_ready, dp_write, dp_pixel, out_valid, out_data, out_row, out_col, busy, done
  );

  modport slave (
    output start, pix_valid, pix_data, dp_result,
    input  pix_ready, dp_write, dp_pixel, out_valid, out_data, out_row, out_col, busy, done
  );
endinterface

// File: rtl/conv_controller.sv
// Frame sequencer for the 2-D convolution datapath with latency-matched output tagging.
// Optional macro CONV_CTRL_RELU_EN clamps negative results to zero on the output.
module conv_controller #(
  parameter int DATA_WIDTH   = 16,
  parameter int KERNEL_SIZE  = 5,
  parameter int IMAGE_SIZE   = 28,
  parameter int PIPE_LATENCY = 2
) (
  input logic               clk,
  input logic               reset,
  conv_controller_if.master bus
);
  localparam int CW = $clog2(IMAGE_SIZE);
  localparam logic [CW-1:0] LAST_IDX   = CW'(IMAGE_SIZE - 1);
  localparam logic [CW-1:0] KM1        = CW'(KERNEL_SIZE - 1);
  localparam logic [4:0]    DRAIN_LAST = 5'(PIPE_LATENCY);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

  state_t                       state, state_next;
  logic [CW-1:0]                row, col;
  logic [4:0]                   drain_cnt;
  logic                         accept, win, last_pix, tag_in;
  logic signed [DATA_WIDTH-1:0] result_s;

  // Stage 0 is registered alongside dp_write; stages 1..PIPE_LATENCY track the datapath.
  logic          tag_v [0:PIPE_LATENCY];
  logic [CW-1:0] tag_r [0:PIPE_LATENCY];
  logic [CW-1:0] tag_c [0:PIPE_LATENCY];

  assign accept   = (state == LOAD) && bus.pix_valid;
  assign win      = (row >= KM1) && (col >= KM1);
  assign last_pix = (row == LAST_IDX) && (col == LAST_IDX);
  assign tag_in   = accept && win;
  assign result_s = bus.dp_result;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next    = state;
    bus.pix_ready = 1'b0;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    case (state)
      IDLE: if (bus.start) state_next = LOAD;
      LOAD: begin
        bus.pix_ready = 1'b1;
        bus.busy      = 1'b1;
        if (accept && last_pix) state_next = DRAIN;
      end
      DRAIN: begin
        bus.busy = 1'b1;
        if (drain_cnt == DRAIN_LAST) state_next = DONE;
      end
      DONE: begin
        bus.done   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row       <= '0;
      col       <= '0;
      drain_cnt <= '0;
    end else begin
      if (state == IDLE && bus.start) begin
        row <= '0;
        col <= '0;
      end else if (accept) begin
        if (col == LAST_IDX) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      drain_cnt <= (state == DRAIN) ? drain_cnt + 5'd1 : 5'd0;
    end
  end

  // Tag pipeline shifts every cycle so idle input cycles become win=0 bubbles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.dp_write  <= 1'b0;
      bus.dp_pixel  <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_row   <= '0;
      bus.out_col   <= '0;
      for (int i = 0; i <= PIPE_LATENCY; i++) begin
        tag_v[i] <= 1'b0;
        tag_r[i] <= '0;
        tag_c[i] <= '0;
      end
    end else begin
      bus.dp_write <= accept;
      if (accept) bus.dp_pixel <= bus.pix_data;
      tag_v[0] <= tag_in;
      tag_r[0] <= tag_in ? row - KM1 : '0;
      tag_c[0] <= tag_in ? col - KM1 : '0;
      for (int i = 1; i <= PIPE_LATENCY; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_r[i] <= tag_r[i-1];
        tag_c[i] <= tag_c[i-1];
      end
      bus.out_valid <= tag_v[PIPE_LATENCY];
      bus.out_row   <= tag_r[PIPE_LATENCY];
      bus.out_col   <= tag_c[PIPE_LATENCY];
`ifdef CONV_CTRL_RELU_EN
      bus.out_data  <= (result_s < 0) ? '0 : result_s;
`else
      bus.out_data  <= result_s;
`endif
    end
  end
endmodule

// File: tb/tb_conv_controller.sv
// Directed bench for conv_controller: full, throttled, aborted and clamped frames
// against a behavioural datapath stand-in.
module tb_conv_controller;
  localparam int DW = 16;
  localparam int KS = 5;
  localparam int IS = 28;
  localparam int PL = 2;
  localparam int OS = IS - KS + 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  conv_controller_if #(.DATA_WIDTH(DW), .IMAGE_SIZE(IS)) ifc ();

  conv_controller #(
    .DATA_WIDTH(DW), .KERNEL_SIZE(KS), .IMAGE_SIZE(IS), .PIPE_LATENCY(PL)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(ifc.master)
  );

  int testsRun = 0;
  int failCount = 0;

  // mode 0: result = 25 x pixel; 1: result = pixel (index coded); 2: result forced to -1.0
  int mode = 0;
  logic monClear = 1'b1;

  // Datapath stand-in: result appears PL cycles after the write strobe.
  logic [DW-1:0] dline [0:PL-1];
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < PL; i++) dline[i] <= '0;
    end else begin
      dline[0] <= (mode == 0) ? 16'(ifc.dp_pixel * 16'd25) : ifc.dp_pixel;
      for (int i = 1; i < PL; i++) dline[i] <= dline[i-1];
    end
  end
  assign ifc.dp_result = (mode == 2) ? 16'hFF00 : dline[PL-1];

  int cyc = 0;
  int outCount, doneCount, coordErrs, dataErrs, writeErrs, hsCount;
  int expR, expC, firstR, firstC, lastR, lastC, firstCycle, hsCycle;
  bit hsPrev;
  logic [DW-1:0] expData;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (monClear) begin
      outCount = 0; doneCount = 0; coordErrs = 0; dataErrs = 0; writeErrs = 0;
      hsCount = 0; expR = 0; expC = 0; firstR = -1; firstC = -1; lastR = -1; lastC = -1;
      firstCycle = 0; hsCycle = 0; hsPrev = 0;
    end else begin
      if (ifc.out_valid) begin
        if (outCount == 0) begin
          firstCycle = cyc;
          firstR = int'(ifc.out_row);
          firstC = int'(ifc.out_col);
        end
        if (int'(ifc.out_row) != expR || int'(ifc.out_col) != expC) coordErrs++;
        if (mode == 0) expData = 16'h1900;
        else if (mode == 1) expData = 16'((expR + KS - 1) * IS + expC + KS - 1);
`ifdef CONV_CTRL_RELU_EN
        else expData = 16'h0000;
`else
        else expData = 16'hFF00;
`endif
        if (ifc.out_data !== expData) dataErrs++;
        lastR = int'(ifc.out_row);
        lastC = int'(ifc.out_col);
        if (expC == OS - 1) begin
          expC = 0;
          expR++;
        end else begin
          expC++;
        end
        outCount++;
      end
      if (ifc.done) doneCount++;
      if (ifc.dp_write !== hsPrev) writeErrs++;
      hsPrev = ifc.pix_valid && ifc.pix_ready;
      if (hsPrev && hsCount == (KS - 1) * IS + (KS - 1)) hsCycle = cyc;
      if (hsPrev) hsCount++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clearMonitor();
    monClear = 1'b1;
    @(negedge clk);
    #1;
    monClear = 1'b0;
  endtask

  task automatic startFrame();
    ifc.start = 1'b1;
    tick(1);
    ifc.start = 1'b0;
  endtask

  // Feeds pixels in raster order until stopAfter have been accepted (bounded by a cycle budget).
  task automatic applyStimulus(input bit throttle, input int stopAfter, input bit pokeStart);
    int idx = 0;
    int n = 0;
    bit phase = 1'b1;
    bit acc;
    while (idx < stopAfter && n < 4000) begin
      ifc.pix_valid = throttle ? phase : 1'b1;
      ifc.pix_data  = (mode == 1) ? 16'(idx) : 16'h0100;
      ifc.start     = pokeStart && (idx % 50 == 7);
      phase = ~phase;
      acc = ifc.pix_valid && ifc.pix_ready;
      tick(1);
      if (acc) idx++;
      n++;
    end
    ifc.pix_valid = 1'b0;
    ifc.start     = 1'b0;
    checkOutput("pixels_accepted", idx, stopAfter);
  endtask

  task automatic waitDone(input bit pokeOnDone);
    int n = 0;
    while (ifc.done !== 1'b1 && n < 200) begin
      tick(1);
      n++;
    end
    checkOutput("done_seen", ifc.done, 1'b1);
    if (pokeOnDone) ifc.start = 1'b1;
    tick(1);
    ifc.start = 1'b0;
    tick(4);
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_pix_ready"}, ifc.pix_ready, 1'b0);
    checkOutput({tag, "_dp_write"}, ifc.dp_write, 1'b0);
    checkOutput({tag, "_out_valid"}, ifc.out_valid, 1'b0);
    checkOutput({tag, "_busy"}, ifc.busy, 1'b0);
    checkOutput({tag, "_done"}, ifc.done, 1'b0);
    checkOutput({tag, "_out_row"}, ifc.out_row, 5'd0);
    checkOutput({tag, "_out_col"}, ifc.out_col, 5'd0);
    checkOutput({tag, "_out_data"}, ifc.out_data, 16'h0000);
  endtask

  task automatic checkFrame(input string tag);
    checkOutput({tag, "_out_count"}, outCount, OS * OS);
    checkOutput({tag, "_done_count"}, doneCount, 1);
    checkOutput({tag, "_coord_errs"}, coordErrs, 0);
    checkOutput({tag, "_data_errs"}, dataErrs, 0);
    checkOutput({tag, "_write_errs"}, writeErrs, 0);
    checkOutput({tag, "_first_row"}, firstR, 0);
    checkOutput({tag, "_first_col"}, firstC, 0);
    checkOutput({tag, "_last_row"}, lastR, OS - 1);
    checkOutput({tag, "_last_col"}, lastC, OS - 1);
    checkOutput({tag, "_busy_after"}, ifc.busy, 1'b0);
    checkOutput({tag, "_ready_after"}, ifc.pix_ready, 1'b0);
  endtask

  initial begin
    ifc.start     = 1'b0;
    ifc.pix_valid = 1'b0;
    ifc.pix_data  = '0;

    #100;
    checkIdleOutputs("in_reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    ifc.pix_valid = 1'b1;
    tick(5);
    checkIdleOutputs("idle");
    ifc.pix_valid = 1'b0;
    clearMonitor();

    // Frame 1: continuous input, constant pixels, start poked during LOAD and DRAIN.
    mode = 0;
    startFrame();
    checkOutput("busy_load", ifc.busy, 1'b1);
    checkOutput("ready_load", ifc.pix_ready, 1'b1);
    applyStimulus(1'b0, IS * IS, 1'b1);
    checkOutput("ready_drain", ifc.pix_ready, 1'b0);
    checkOutput("busy_drain", ifc.busy, 1'b1);
    ifc.start = 1'b1;
    tick(2);
    ifc.start = 1'b0;
    waitDone(1'b1);
    checkFrame("frame1");
    // handshake seen at negedge N, accepted at the next edge, out_valid PL+1 edges later
    checkOutput("frame1_latency", firstCycle - hsCycle, PL + 2);
    tick(3);
    checkOutput("no_restart_busy", ifc.busy, 1'b0);
    checkOutput("no_restart_done", doneCount, 1);
    clearMonitor();

    // Frame 2: pix_valid toggling every cycle, index-coded pixels check alignment.
    mode = 1;
    startFrame();
    applyStimulus(1'b1, IS * IS, 1'b0);
    waitDone(1'b0);
    checkFrame("throttled");
    checkOutput("throttled_latency", firstCycle - hsCycle, PL + 2);
    clearMonitor();

    // Frame 3: aborted by reset after 300 pixels, then a clean frame.
    startFrame();
    applyStimulus(1'b0, 300, 1'b0);
    tick(1);
    reset = 1'b1;
    tick(1);
    checkIdleOutputs("mid_reset");
    tick(3);
    reset = 1'b0;
    tick(PL + 6);
    checkOutput("abort_no_done", doneCount, 0);
    checkIdleOutputs("after_abort");
    clearMonitor();
    startFrame();
    applyStimulus(1'b0, IS * IS, 1'b0);
    waitDone(1'b0);
    checkFrame("after_abort");
    clearMonitor();

    // Frame 4: datapath result forced negative.
    mode = 2;
    startFrame();
    applyStimulus(1'b0, IS * IS, 1'b0);
    waitDone(1'b0);
    checkFrame("negative");
`ifdef CONV_CTRL_RELU_EN
    checkOutput("negative_out_data", ifc.out_data, 16'h0000);
`else
    checkOutput("negative_out_data", ifc.out_data, 16'hFF00);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end
endmodule

// File: doc/conv_controller.md
Name: conv_controller

Overview:
- Sequencer for the 2-D convolution datapath.
- Accepts a raster-order pixel stream for one IMAGE_SIZE x IMAGE_SIZE image (valid/ready handshake) and drives the datapath write strobe and pixel input.
- Tracks row/column position and flags which datapath results are valid convolution outputs (window fully inside the image), with the datapath pipeline latency compensated.
- Tags each valid output with its output coordinates and signals frame completion.

Parameters:
- DATA_WIDTH, 16, fixed-point word width of pixels and results.
- KERNEL_SIZE, 5, square kernel edge length.
- IMAGE_SIZE, 28, square input image edge length.
- PIPE_LATENCY, 2, cycles from datapath write to the corresponding add_result; range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin a frame; sampled only in IDLE.
- pix_valid  in  1  pix_data holds a valid pixel.
- pix_data  in  DATA_WIDTH  signed input pixel.
- pix_ready  out  1  controller accepts a pixel this cycle.
- dp_write  out  1  datapath write strobe.
- dp_pixel  out  DATA_WIDTH  pixel to datapath pixel_input.
- dp_result  in  DATA_WIDTH  datapath add_result.
- out_valid  out  1  out_data is a valid convolution output.
- out_data  out  DATA_WIDTH  convolution result.
- out_row  out  $clog2(IMAGE_SIZE)  output row index, 0..IMAGE_SIZE-KERNEL_SIZE.
- out_col  out  $clog2(IMAGE_SIZE)  output column index, 0..IMAGE_SIZE-KERNEL_SIZE.
- busy  out  1  high in LOAD and DRAIN.
- done  out  1  one-cycle pulse at frame end.

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0; latency delay line cleared.
- FSM IDLE -> LOAD:
  - Taken on start=1.
  - Row and column counters clear to 0.
- FSM LOAD:
  - pix_ready=1.
  - A pixel is accepted only when pix_valid & pix_ready. There is no other side effect of pix_valid.
  - On acceptance: dp_write=1 and dp_pixel=pix_data, both registered, so they appear 1 cycle after the handshake.
  - On acceptance: col increments. When col wraps IMAGE_SIZE-1 -> 0, row increments.
  - Accepting pixel (IMAGE_SIZE-1, IMAGE_SIZE-1) moves the FSM to DRAIN; pix_ready is 0 from the next cycle.
- Window tag:
  - win = (row >= KERNEL_SIZE-1) && (col >= KERNEL_SIZE-1), evaluated for the accepted pixel.
  - Tag content is {win, row-(KERNEL_SIZE-1), col-(KERNEL_SIZE-1)}.
  - The tag enters a PIPE_LATENCY-deep shift register aligned with dp_write. The shift register advances every cycle, with bubbles carrying win=0.
- Output:
  - out_valid, out_row and out_col come from the shift register tail.
  - out_data = dp_result, registered in the same cycle as the tail.
  - Total latency from pixel handshake to out_valid is PIPE_LATENCY+1 cycles.
  - There is no output backpressure.
- FSM DRAIN:
  - A counter waits PIPE_LATENCY+1 cycles so the last tag exits.
  - Then -> DONE.
- FSM DONE:
  - done=1 for exactly one cycle, then -> IDLE.
  - busy=0 in DONE and IDLE.
- Output count: exactly (IMAGE_SIZE-KERNEL_SIZE+1)^2 out_valid pulses per frame (576 with defaults), in raster order.
- Boundaries:
  - start while not in IDLE is ignored.
  - pix_valid in IDLE, DRAIN or DONE is ignored; pix_ready=0 there.
  - Gaps in pix_valid stall the counters; tags stay aligned because bubbles are inserted.
  - reset asserted mid-frame immediately returns all state to reset values. Any partial frame is discarded, and no done pulse is emitted.
  - start asserted in the same cycle the controller returns from DONE to IDLE is not seen; start is sampled in the following IDLE cycle.
- Width rules:
  - Counters are $clog2(IMAGE_SIZE) bits.
  - Subtractions for tags are performed only when win=1. Tag fields are 0 otherwise.

Optional Feature:
- Macro: CONV_CTRL_RELU_EN.
- Defined: out_data = (dp_result < 0) ? 0 : dp_result, signed compare, with no added latency.
- Undefined: out_data = dp_result unmodified.

Test Plan:
- Reset then idle: reset=1 for 100 ns then 0, start=0 -> all outputs 0, pix_ready=0, no dp_write.
- Full frame, continuous pix_valid, datapath configured with all weights 0x0100, pixels 0x0100, bias 0 -> first out_valid exactly PIPE_LATENCY+1 cycles after pixel (4,4) handshake; out_data=0x1900; 576 out_valid pulses; first tag (0,0), last tag (23,23); done pulses once.
- Throttled input, pix_valid toggling 1/0 each cycle -> same 576 outputs with identical coordinates; dp_write only on accepted cycles.
- Reset asserted at pixel 300, then a new start -> no done pulse from the aborted frame; the new frame produces 576 outputs starting at (0,0).
- start asserted during LOAD and DRAIN -> ignored; exactly one done pulse per frame.
- With CONV_CTRL_RELU_EN, dp_result forced to 0xFF00 (-1.0) -> out_data=0x0000. Without the macro -> out_data=0xFF00.
